// File: rtl/fifo_stream_reader.sv
// Read-side master for sync_fifo: pops words and re-presents them as a valid/ready stream
// framed in bursts of BURST_LEN beats, with a 2-entry skid buffer for full-rate backpressure.
module fifo_stream_reader #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] fifo_rdata,
   input  logic             fifo_rempty,
   output logic             fifo_rinc,
   output logic [WIDTH-1:0] m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   output logic             busy
);

   localparam int unsigned   CW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FLUSH
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    iss_cnt_q, iss_cnt_d;
   logic [CW-1:0]    out_cnt_q, out_cnt_d;
   logic             infl_q;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             skid_v_q, skid_v_d;

   logic             can_issue;
   logic             pop;
   logic             land;
   logic [1:0]       occ;
   logic [2:0]       committed;

   function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
      return (v == LAST) ? '0 : v + 1'b1;
   endfunction

   assign pop       = valid_q & m_tready;
   assign land      = infl_q;
   assign occ       = {1'b0, valid_q} + {1'b0, skid_v_q};
   // Entries held plus the word in flight, minus the one leaving; pop implies occ>=1
   assign committed = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
   assign fifo_rinc = can_issue & ~fifo_rempty & (committed < 3'd2);

   assign m_tdata   = data_q;
   assign m_tvalid  = valid_q;
   assign m_tlast   = last_q;
   assign busy      = (state_q != S_IDLE);

   always_comb begin
      state_d   = state_q;
      can_issue = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_RUN;
         end
         S_RUN: begin
            can_issue = 1'b1;
            if (!en) state_d = (iss_cnt_q == '0) ? S_FLUSH : S_DRAIN;
         end
         S_DRAIN: begin
            can_issue = (iss_cnt_q != '0);
            if (en)                   state_d = S_RUN;
            else if (iss_cnt_q == '0) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (en)                            state_d = S_RUN;
            else if ((occ == 2'd0) && !infl_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_cnt_d = pop ? wrap_inc(out_cnt_q) : out_cnt_q;
      iss_cnt_d = fifo_rinc ? wrap_inc(iss_cnt_q) : iss_cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      skid_d    = skid_q;
      skid_v_d  = skid_v_q;
      // Every earlier beat has left by the time a word loads the output register,
      // so the post-pop beat count is exactly this word's position in the burst.
      if (!valid_q || m_tready) begin
         if (skid_v_q) begin
            data_d   = skid_q;
            valid_d  = 1'b1;
            last_d   = (out_cnt_d == LAST);
            skid_v_d = land;
            if (land) skid_d = fifo_rdata;
         end else if (land) begin
            data_d  = fifo_rdata;
            valid_d = 1'b1;
            last_d  = (out_cnt_d == LAST);
         end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      end else if (land) begin
         skid_v_d = 1'b1;
         skid_d   = fifo_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         iss_cnt_q <= '0;
         out_cnt_q <= '0;
         infl_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         skid_q    <= '0;
         skid_v_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         iss_cnt_q <= iss_cnt_d;
         out_cnt_q <= out_cnt_d;
         infl_q    <= fifo_rinc;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         skid_q    <= skid_d;
         skid_v_q  <= skid_v_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: behavioural FIFO, in-order scoreboard with
// burst-position tlast, and directed scenarios for stall, drain, gaps and mid-burst reset.
module tb_fifo_stream_reader;

   localparam int unsigned W  = 32;
   localparam int unsigned BL = 4;

   logic         clk         = 1'b0;
   logic         rst_n       = 1'b0;
   logic         en          = 1'b0;
   logic         m_tready    = 1'b0;
   logic         wr_en       = 1'b0;
   logic [W-1:0] wr_data     = '0;
   logic [W-1:0] fifo_rdata  = '0;
   logic         fifo_rempty = 1'b1;
   logic         fifo_rinc;
   logic [W-1:0] m_tdata;
   logic         m_tvalid;
   logic         m_tlast;
   logic         busy;

   logic [W-1:0] fq[$];
   logic [W-1:0] exp_mem [0:255];
   logic [7:0]   wr_idx = '0;
   logic [7:0]   rd_idx = '0;
   int unsigned  beat    = 0;
   int unsigned  n_beats = 0;
   int unsigned  n_rinc  = 0;
   int unsigned  n_chk   = 0;
   int unsigned  n_pass  = 0;
   logic         last_tlast = 1'b0;
   logic         prev_stall = 1'b0;
   logic         prev_last  = 1'b0;
   logic [W-1:0] prev_data  = '0;
   logic         underflow  = 1'b0;

   fifo_stream_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .fifo_rdata (fifo_rdata),
      .fifo_rempty(fifo_rempty),
      .fifo_rinc  (fifo_rinc),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Behavioural sync_fifo sharing the block's reset; read data appears the cycle after rinc
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq.delete();
         fifo_rdata  <= '0;
         fifo_rempty <= 1'b1;
      end else begin
         if (fifo_rinc) begin
            if (fq.size() == 0) underflow <= 1'b1;
            else fifo_rdata <= fq.pop_front();
         end
         if (wr_en) fq.push_back(wr_data);
         fifo_rempty <= (fq.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         rd_idx     = wr_idx;
         beat       = 0;
         prev_stall = 1'b0;
      end else begin
         if (fifo_rinc) begin
            chk("rinc_while_empty", 64'(fifo_rempty), 64'(0));
            n_rinc++;
         end
         if (m_tlast) chk("tlast_without_valid", 64'(m_tvalid), 64'(1));
         if (prev_stall) begin
            chk("hold_valid", 64'(m_tvalid), 64'(1));
            chk("hold_data", 64'(m_tdata), 64'(prev_data));
            chk("hold_last", 64'(m_tlast), 64'(prev_last));
         end
         if (m_tvalid && m_tready) begin
            chk("beat_expected", 64'(rd_idx != wr_idx), 64'(1));
            if (rd_idx != wr_idx) begin
               chk("beat_data", 64'(m_tdata), 64'(exp_mem[rd_idx]));
               chk("beat_last", 64'(m_tlast), 64'((beat % BL) == BL - 1));
               rd_idx++;
            end
            beat++;
            n_beats++;
            last_tlast = m_tlast;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] w);
      exp_mem[wr_idx] = w;
      wr_idx++;
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      en       = 1'b0;
      m_tready = 1'b0;
      wr_en    = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_beats(input int unsigned target, input int unsigned budget, input string tag);
      int unsigned c = 0;
      while (n_beats < target && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk(tag, 64'(n_beats >= target), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned  cnt;
      int unsigned  base_b;
      int unsigned  base_r;
      logic         r_rinc [0:15];
      logic         r_v    [0:15];
      logic [W-1:0] r_d    [0:15];
      logic         r_l    [0:15];

      // 1: reset with random inputs, then idle with a non-empty FIFO
      for (int c = 0; c < 6; c++) begin
         en       = 1'($urandom);
         m_tready = 1'($urandom);
         wr_en    = 1'($urandom);
         wr_data  = $urandom;
         @(negedge clk);
         chk("reset_outputs", 64'({m_tvalid, m_tlast, fifo_rinc, busy, m_tdata}), 64'(0));
         tick();
      end
      wr_en    = 1'b0;
      en       = 1'b0;
      m_tready = 1'b1;
      rst_n    = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) push($urandom);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("idle_rinc", 64'(fifo_rinc), 64'(0));
         chk("idle_busy", 64'(busy), 64'(0));
         tick();
      end

      // 2: full-rate burst of 0..7
      do_reset();
      for (int i = 0; i < 8; i++) push(W'(i));
      m_tready = 1'b1;
      en       = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         r_rinc[c] = fifo_rinc;
         r_v[c]    = m_tvalid;
         r_d[c]    = m_tdata;
         r_l[c]    = m_tlast;
         tick();
      end
      for (int c = 0; c < 16; c++) begin
         chk("t2_rinc", 64'(r_rinc[c]), 64'(c >= 1 && c <= 8));
         chk("t2_valid", 64'(r_v[c]), 64'(c >= 3 && c <= 10));
         if (c >= 3 && c <= 10) begin
            chk("t2_data", 64'(r_d[c]), 64'(c - 3));
            chk("t2_last", 64'(r_l[c]), 64'(((c - 3) % 4) == 3));
         end
      end

      // 3: backpressure at start, then release
      do_reset();
      for (int i = 0; i < 10; i++) push($urandom);
      base_b   = n_beats;
      base_r   = n_rinc;
      m_tready = 1'b0;
      en       = 1'b1;
      cnt      = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (fifo_rinc) cnt++;
         tick();
      end
      chk("t3_rinc_stalled", 64'(cnt), 64'(2));
      m_tready = 1'b1;
      wait_beats(base_b + 10, 200, "t3_timeout");
      repeat (4) tick();
      chk("t3_beats", 64'(n_beats - base_b), 64'(10));
      chk("t3_rinc_total", 64'(n_rinc - base_r), 64'(10));
      chk("t3_all_consumed", 64'(rd_idx), 64'(wr_idx));

      // 4: en drops after the 2nd rinc -> finish exactly one burst
      do_reset();
      for (int i = 0; i < 8; i++) push($urandom);
      base_b   = n_beats;
      base_r   = n_rinc;
      m_tready = 1'b1;
      en       = 1'b1;
      cnt      = 0;
      for (int c = 0; c < 20 && cnt < 2; c++) begin
         @(negedge clk);
         if (fifo_rinc) cnt++;
         tick();
      end
      en = 1'b0;
      repeat (15) tick();
      @(negedge clk);
      chk("t4_beats", 64'(n_beats - base_b), 64'(4));
      chk("t4_rinc_total", 64'(n_rinc - base_r), 64'(4));
      chk("t4_last_on_4th", 64'(last_tlast), 64'(1));
      chk("t4_busy", 64'(busy), 64'(0));
      chk("t4_rinc_idle", 64'(fifo_rinc), 64'(0));
      chk("t4_fifo_left", 64'(fq.size()), 64'(4));
      tick();

      // 5: FIFO runs dry mid-burst, then refills
      do_reset();
      for (int i = 0; i < 2; i++) push($urandom);
      base_b   = n_beats;
      m_tready = 1'b1;
      en       = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      chk("t5_first_two", 64'(n_beats - base_b), 64'(2));
      chk("t5_gap_valid", 64'(m_tvalid), 64'(0));
      chk("t5_gap_busy", 64'(busy), 64'(1));
      chk("t5_no_early_last", 64'(last_tlast), 64'(0));
      tick();
      for (int i = 0; i < 2; i++) push($urandom);
      wait_beats(base_b + 4, 50, "t5_timeout");
      repeat (3) tick();
      chk("t5_beats", 64'(n_beats - base_b), 64'(4));
      chk("t5_last_on_4th", 64'(last_tlast), 64'(1));

      // 6: one-cycle reset mid-burst with a word in flight
      do_reset();
      for (int i = 0; i < 8; i++) push($urandom);
      m_tready = 1'b1;
      en       = 1'b1;
      wait_beats(n_beats + 2, 30, "t6_pre_timeout");
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_reset_outputs", 64'({m_tvalid, m_tlast, fifo_rinc, busy, m_tdata}), 64'(0));
      tick();
      rst_n  = 1'b1;
      base_b = n_beats;
      tick();
      for (int i = 0; i < 4; i++) push($urandom);
      wait_beats(base_b + 4, 50, "t6_timeout");
      repeat (3) tick();
      chk("t6_beats", 64'(n_beats - base_b), 64'(4));
      chk("t6_last_on_4th", 64'(last_tlast), 64'(1));

      chk("fifo_underflow", 64'(underflow), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
